// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyzer capture path.
// Used by the capture controller, the sample buffer and the status register block.
package la_pkg;

  localparam int LA_M     = 16;  // default sample/word width
  localparam int LA_CNT_W = 16;  // default post-trigger counter width
  localparam int LA_ST_W  = 3;   // width of the encoded status state

  // Encoding is visible to software through the status readout; keep values fixed.
  typedef enum logic [LA_ST_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_DONE    = 3'd3,
    ST_ERROR   = 3'd4
  } la_state_e;

  // A capture is in progress while waiting for, or storing after, the trigger.
  function automatic logic st_busy(input la_state_e s);
    return (s == ST_ARMED) || (s == ST_CAPTURE);
  endfunction

endpackage

// File: rtl/la_capture_ctrl_if.sv
// Sampler/buffer side bundle of the capture controller.
// master: the controller (consumes samples, drives the buffer write port).
// slave:  the environment (sampler front end + buffer).
interface la_capture_ctrl_if
  import la_pkg::*;
#(
  parameter int M = LA_M
);
  logic [M-1:0] sample;
  logic         sample_vld;
  logic         buf_overflow;
  logic [M-1:0] word_out;
  logic         word_stb;

  modport master (
    input  sample,
    input  sample_vld,
    input  buf_overflow,
    output word_out,
    output word_stb
  );

  modport slave (
    output sample,
    output sample_vld,
    output buf_overflow,
    input  word_out,
    input  word_stb
  );
endinterface

// File: rtl/la_trig_match.sv
// Combinational trigger matcher: masked level compare, plus an optional
// per-bit edge requirement against the previous valid sample.
// Build option: TRIG_EDGE_EN enables the edge term; otherwise edge_i is ignored.
module la_trig_match
  import la_pkg::*;
#(
  parameter int M = LA_M
)(
  input  logic [M-1:0] sample_i,
  input  logic [M-1:0] prev_i,
  input  logic         prev_vld_i,
  input  logic [M-1:0] mask_i,
  input  logic [M-1:0] value_i,
  input  logic [M-1:0] edge_i,
  output logic         hit_o
);

  logic lvl_ok;
  logic edge_ok;

  assign lvl_ok = (((sample_i ^ value_i) & mask_i) == '0);

`ifdef TRIG_EDGE_EN
  // Every edge-qualified bit must differ from the previous sample; with no
  // history yet, only an empty edge set can pass.
  assign edge_ok = (edge_i == '0) ||
                   (prev_vld_i && (((~(sample_i ^ prev_i)) & edge_i) == '0));
`else
  logic unused_edge;
  assign unused_edge = ^{prev_i, prev_vld_i, edge_i};
  assign edge_ok     = 1'b1;
`endif

  assign hit_o = lvl_ok && edge_ok;

endmodule

// File: rtl/la_capture_ctrl.sv
// Logic-analyzer capture sequencer: arm, wait for trigger, then push the
// trigger sample plus post_count further samples into the circular buffer
// via a paced word/strobe write port.
// Build option: TRIG_EDGE_EN adds edge-qualified triggering with a history register.
module la_capture_ctrl
  import la_pkg::*;
#(
  parameter int M      = LA_M,
  parameter int CNT_W  = LA_CNT_W,
  parameter int STB_HI = 2,
  parameter int GAP    = 4
)(
  input  logic                rdclk_i,
  input  logic                nreset_i,
  input  logic                en_i,
  input  logic                arm_i,
  input  logic                abort_i,
  input  logic [M-1:0]        trig_mask_i,
  input  logic [M-1:0]        trig_value_i,
  input  logic [M-1:0]        trig_edge_i,
  input  logic [CNT_W-1:0]    post_count_i,
  la_capture_ctrl_if.master   bus,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [LA_ST_W-1:0]  state_o
);

  // Gap timer: loaded with GAP-1 on a strobe rise, counts down to 0.
  // Zero means the next rise may happen on the following edge.
  localparam int              TW       = $clog2(GAP + 1);
  localparam logic [TW-1:0]   TMR_LOAD = TW'(GAP - 1);
  localparam logic [TW-1:0]   STB_LAST = TW'(GAP - STB_HI);

  la_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic             stb_q, stb_d;
  logic [M-1:0]     word_q, word_d;
  logic             err_q, err_d;

  logic             gap_free;
  logic             start;
  logic             hit;
  logic [M-1:0]     prev_s;
  logic             prev_vld_s;

  assign gap_free = (tmr_q == '0);

  la_trig_match #(.M(M)) u_match (
    .sample_i   (bus.sample),
    .prev_i     (prev_s),
    .prev_vld_i (prev_vld_s),
    .mask_i     (trig_mask_i),
    .value_i    (trig_value_i),
    .edge_i     (trig_edge_i),
    .hit_o      (hit)
  );

  // Next-state, counter, error and strobe-start decisions.
  // A trigger seen while a previous strobe's gap window is still open (only
  // possible right after abort/overflow) is not taken, so the trigger sample
  // is always the first word actually written.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    start   = 1'b0;
    if (abort_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (arm_i) begin
            state_d = ST_ARMED;
            cnt_d   = post_count_i;
            err_d   = 1'b0;
          end
        end
        ST_ARMED: begin
          if (bus.buf_overflow) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end else if (bus.sample_vld && hit && gap_free) begin
            state_d = ST_CAPTURE;
            start   = 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (bus.buf_overflow) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end else if (cnt_q == '0) begin
            // All words issued; finish once the last strobe and its gap are over.
            if (gap_free) state_d = ST_DONE;
          end else if (bus.sample_vld) begin
            if (gap_free) begin
              start = 1'b1;
              cnt_d = cnt_q - CNT_W'(1);
            end else begin
              err_d = 1'b1;  // sample lost: buffer port still busy
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Write-port pacing: word latched at strobe start, strobe held STB_HI cycles.
  always_comb begin
    word_d = start ? bus.sample : word_q;
    tmr_d  = start ? TMR_LOAD : (gap_free ? tmr_q : tmr_q - TW'(1));
    stb_d  = start | (stb_q & (tmr_q > STB_LAST));
  end

  // State and datapath registers; en_i freezes everything, reset overrides it.
  always_ff @(posedge rdclk_i) begin
    if (!nreset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tmr_q   <= '0;
      stb_q   <= 1'b0;
      word_q  <= '0;
      err_q   <= 1'b0;
    end else if (en_i) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      stb_q   <= stb_d;
      word_q  <= word_d;
      err_q   <= err_d;
    end
  end

`ifdef TRIG_EDGE_EN
  logic [M-1:0] prev_q, prev_d;
  logic         hist_q, hist_d;

  // Edge history restarts on every entry to ARMED; each valid sample seen
  // while ARMED becomes the reference for the next one.
  always_comb begin
    prev_d = prev_q;
    hist_d = hist_q;
    if (state_q != ST_ARMED && state_d == ST_ARMED) begin
      hist_d = 1'b0;
    end else if (state_q == ST_ARMED && bus.sample_vld) begin
      prev_d = bus.sample;
      hist_d = 1'b1;
    end
  end

  // History registers follow the same reset/enable rules as the main state.
  always_ff @(posedge rdclk_i) begin
    if (!nreset_i) begin
      prev_q <= '0;
      hist_q <= 1'b0;
    end else if (en_i) begin
      prev_q <= prev_d;
      hist_q <= hist_d;
    end
  end

  assign prev_s     = prev_q;
  assign prev_vld_s = hist_q;
`else
  assign prev_s     = '0;
  assign prev_vld_s = 1'b0;
`endif

  assign bus.word_out = word_q;
  assign bus.word_stb = stb_q;
  assign busy_o       = st_busy(state_q);
  assign done_o       = (state_q == ST_DONE);
  assign err_o        = err_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_la_capture_ctrl.sv
// Self-checking bench for la_capture_ctrl: directed scenarios plus a random
// phase, all checked every cycle against a timestamp-based reference model.
module tb_la_capture_ctrl;
  import la_pkg::*;

  localparam int M = 16, CNT_W = 16, STB_HI = 2, GAP = 4;

  logic             clk = 1'b0;
  logic             nrst = 1'b0, en = 1'b1, arm = 1'b0, abort = 1'b0;
  logic [M-1:0]     mask = '0, value = '0, edg = '0;
  logic [CNT_W-1:0] post = '0;
  logic             busy, done, err;
  logic [2:0]       st;

  la_capture_ctrl_if #(.M(M)) bus ();

  always #5 clk = ~clk;

  la_capture_ctrl #(.M(M), .CNT_W(CNT_W), .STB_HI(STB_HI), .GAP(GAP)) dut (
    .rdclk_i(clk), .nreset_i(nrst), .en_i(en), .arm_i(arm), .abort_i(abort),
    .trig_mask_i(mask), .trig_value_i(value), .trig_edge_i(edg),
    .post_count_i(post), .bus(bus),
    .busy_o(busy), .done_o(done), .err_o(err), .state_o(st)
  );

  int total = 0, bad = 0;

  // Reference model: states by spec number, strobe timing by edge timestamps.
  int           m_st = 0, m_rem = 0;
  bit           m_err = 0, m_hv = 0;
  logic [M-1:0] m_prev = '0, m_word = '0;
  longint       e_cnt = 0, m_rise = -100;
  logic [M-1:0] exp_q[$], got_q[$];
  bit           stb_prev = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_hit(input logic [M-1:0] s);
    for (int i = 0; i < M; i++) begin
      if (mask[i] && s[i] !== value[i]) return 1'b0;
`ifdef TRIG_EDGE_EN
      if (edg[i] && (!m_hv || s[i] === m_prev[i])) return 1'b0;
`endif
    end
    return 1'b1;
  endfunction

  task automatic m_write(input logic [M-1:0] s);
    m_word = s;
    m_rise = e_cnt;
    exp_q.push_back(s);
  endtask

  task automatic model_step();
    bit free, vld, ovf;
    logic [M-1:0] s;
    if (!nrst) begin
      if (e_cnt - m_rise < STB_HI && exp_q.size() > 0) void'(exp_q.pop_back());
      m_st = 0; m_rem = 0; m_err = 0; m_hv = 0; m_prev = '0; m_word = '0;
      m_rise = e_cnt - 100;
    end else if (en) begin
      e_cnt++;
      free = (e_cnt - m_rise) >= GAP;
      vld  = bus.sample_vld;
      ovf  = bus.buf_overflow;
      s    = bus.sample;
      if (abort) m_st = 0;
      else if (m_st == 0 || m_st == 3 || m_st == 4) begin
        if (arm) begin m_st = 1; m_rem = int'(post); m_err = 0; m_hv = 0; end
      end else if (m_st == 1) begin
        if (ovf) begin m_st = 4; m_err = 1; end
        else if (vld && m_hit(s) && free) begin m_st = 2; m_write(s); end
        if (vld) begin m_prev = s; m_hv = 1; end
      end else if (m_st == 2) begin
        if (ovf) begin m_st = 4; m_err = 1; end
        else if (m_rem == 0) begin if (free) m_st = 3; end
        else if (vld) begin
          if (free) begin m_write(s); m_rem--; end
          else m_err = 1;
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    if (stb_prev && !bus.word_stb && nrst) got_q.push_back(bus.word_out);
    stb_prev = bus.word_stb;
    chk("state", st, m_st);
    chk("busy", busy, (m_st == 1 || m_st == 2));
    chk("done", done, (m_st == 3));
    chk("err", err, m_err);
    chk("stb", bus.word_stb, ((e_cnt - m_rise) < STB_HI));
    chk("word", bus.word_out, m_word);
    arm = 1'b0; abort = 1'b0; bus.sample_vld = 1'b0; bus.buf_overflow = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic send(input logic [M-1:0] s, input int space);
    bus.sample = s; bus.sample_vld = 1'b1;
    cyc();
    idle(space - 1);
  endtask

  task automatic do_arm(input int pc);
    post = CNT_W'(pc); arm = 1'b1;
    cyc();
  endtask

  task automatic chk_words(input string tag);
    chk({tag, "_nw"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) chk({tag, "_w"}, got_q[i], exp_q[i]);
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    bus.sample = '0; bus.sample_vld = 1'b0; bus.buf_overflow = 1'b0;
    idle(2);
    chk("rst_state", st, ST_IDLE);
    chk("rst_stb", bus.word_stb, 0);
    chk("rst_word", bus.word_out, 0);
    chk("rst_flags", {busy, done, err}, 3'b000);
    nrst = 1'b1;
    cyc();

    // 1: free trigger, post_count=3 -> four words
    mask = '0; value = '0; edg = '0;
    do_arm(3);
    for (int i = 0; i < 5; i++) send(M'(16'h1001 + i), 6);
    idle(4);
    chk("t1_nw", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) chk("t1_word", got_q[i], 16'h1001 + i);
    chk("t1_done", done, 1);
    chk("t1_err", err, 0);
    chk_words("t1");

    // 2: masked level trigger, single word
    mask = 16'h00FF; value = 16'h0042;
    do_arm(0);
    send(16'h0000, 6); send(16'h1142, 6); send(16'h0043, 6);
    idle(4);
    chk("t2_nw", got_q.size(), 1);
    if (got_q.size() > 0) chk("t2_first", got_q[0], 16'h1142);
    chk("t2_done", done, 1);
    chk_words("t2");

    // 3: samples faster than GAP -> alternate drops
    mask = '0;
    do_arm(3);
    for (int i = 0; i < 8; i++) send(M'(16'h3000 + i), 2);
    idle(6);
    chk("t3_nw", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) chk("t3_word", got_q[i], 16'h3000 + 2 * i);
    chk("t3_err", err, 1);
    chk("t3_done", done, 1);
    chk_words("t3");

    // 4: overflow during capture, then re-arm clears err
    do_arm(10);
    send(16'h4000, 6); send(16'h4001, 1);
    bus.buf_overflow = 1'b1; cyc();
    chk("t4_state", st, ST_ERROR);
    chk("t4_err", err, 1);
    send(16'h4002, 6); send(16'h4003, 6);
    idle(2);
    chk("t4_nw", got_q.size(), 2);
    chk_words("t4");
    do_arm(3);
    chk("t4_rearm", st, ST_ARMED);
    chk("t4_errclr", err, 0);

    // 5: arm+abort together while capturing, then reset mid-strobe
    send(16'h5000, 6);
    arm = 1'b1; abort = 1'b1; cyc();
    chk("t5_abort", st, ST_IDLE);
    chk("t5_nw", got_q.size(), 1);
    chk_words("t5a");
    do_arm(5);
    send(16'h5100, 1);
    nrst = 1'b0; cyc();
    chk("t5_rst_stb", bus.word_stb, 0);
    chk("t5_rst_state", st, ST_IDLE);
    nrst = 1'b1;
    idle(6);
    chk("t5_rst_nw", got_q.size(), 0);
    chk_words("t5b");

    // en=0 freezes mid-strobe even with pulses on every input
    do_arm(2);
    send(16'h6000, 1);
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.sample = M'($urandom); bus.sample_vld = 1'b1;
      bus.buf_overflow = (i == 2); arm = (i == 3);
      cyc();
    end
    chk("frz_stb", bus.word_stb, 1);
    chk("frz_state", st, ST_CAPTURE);
    en = 1'b1;
    idle(6);
    send(16'h6001, 6); send(16'h6002, 6);
    idle(4);
    chk("frz_nw", got_q.size(), 3);
    chk("frz_done", done, 1);
    chk_words("frz");

    // 6: edge qualification (level-only in the default build)
    mask = 16'h0001; value = 16'h0001; edg = 16'h0001;
    do_arm(0);
    send(16'h0101, 6); send(16'h0201, 6); send(16'h0300, 6); send(16'h0401, 6);
    idle(4);
    chk("t6_nw", got_q.size(), 1);
`ifdef TRIG_EDGE_EN
    if (got_q.size() > 0) chk("t6_word", got_q[0], 16'h0401);
`else
    if (got_q.size() > 0) chk("t6_word", got_q[0], 16'h0101);
`endif
    chk_words("t6");

    // Random phase
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 49) == 0) begin
        case ($urandom_range(0, 2))
          0:       mask = '0;
          1:       mask = 16'h000F;
          default: mask = 16'h0003;
        endcase
        value = M'($urandom);
        edg   = ($urandom_range(0, 1) != 0) ? 16'h0001 : 16'h0000;
      end
      en    = ($urandom_range(0, 9) != 0);
      nrst  = ($urandom_range(0, 499) != 0);
      arm   = ($urandom_range(0, 11) == 0);
      abort = ($urandom_range(0, 79) == 0);
      post  = CNT_W'($urandom_range(0, 6));
      bus.buf_overflow = ($urandom_range(0, 199) == 0);
      bus.sample_vld   = ($urandom_range(0, 2) == 0);
      bus.sample       = M'($urandom);
      cyc();
    end
    nrst = 1'b1; en = 1'b1;
    abort = 1'b1; cyc();
    idle(10);
    chk_words("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
